// File: rtl/pusch_pkg.sv
// Shared PUSCH front-end definitions: RE count per packet, IQ lane layout and
// the framer state encoding used by ant_iq_framer.
package pusch_pkg;

    localparam int RE_NUM_DEF = 1584;

    typedef struct packed {
        logic [15:0] i;
        logic [15:0] q;
    } iq_lane_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PAD  = 2'd2,
        DROP = 2'd3
    } framer_state_t;

endpackage

// File: rtl/re_addr_cnt.sv
// RE address counter: clear has priority, increment saturates at RE_NUM-1 and
// o_at_last flags the final RE of a symbol. Shared with the buffer read side.
module re_addr_cnt #(
    parameter int ADDR_WIDTH = 11,
    parameter int RE_NUM     = 1584
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_clr,
    input  logic                  i_inc,
    output logic [ADDR_WIDTH-1:0] o_cnt,
    output logic                  o_at_last
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RE_NUM - 1);

    logic [ADDR_WIDTH-1:0] r_cnt;
    logic                  w_at_last;

    assign w_at_last = (r_cnt == LAST_ADDR);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && !w_at_last) begin
            r_cnt <= r_cnt + ADDR_WIDTH'(1);
        end
    end

    assign o_cnt     = r_cnt;
    assign o_at_last = w_at_last;

endmodule

// File: rtl/ant_iq_framer.sv
// ant_iq_framer: turns per-packet antenna IQ beats into addressed RE writes with one
// last per packet, padding short and truncating long packets. Optional counters: ANT_IQ_FRAMER_STAT_EN.
module ant_iq_framer
    import pusch_pkg::*;
#(
    parameter int ANT        = 4,
    parameter int ADDR_WIDTH = 11,
    parameter int RE_NUM     = RE_NUM_DEF
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [ANT*32-1:0]     i_data,
    input  logic                  i_vld,
    input  logic                  i_sop,
    input  logic                  i_eop,
    output logic                  o_ready,
    output logic [ADDR_WIDTH-1:0] o_iq_addr,
    output logic [ANT*32*32-1:0]  o_iq_data,
    output logic                  o_iq_vld,
    output logic                  o_iq_last,
    output logic                  o_ant_sel,
    output logic                  o_err_short,
    output logic                  o_err_long
`ifdef ANT_IQ_FRAMER_STAT_EN
    ,
    output logic [31:0]           o_pkt_cnt,
    output logic [15:0]           o_short_cnt,
    output logic [15:0]           o_long_cnt
`endif
);

    localparam int OUT_LANES = ANT * 32;

    framer_state_t         r_state;
    framer_state_t         w_state_next;
    logic                  r_ready_base;
    logic [ADDR_WIDTH-1:0] r_iq_addr;
    iq_lane_t              r_iq_lane [ANT];
    iq_lane_t              w_in_lane [ANT];
    logic                  r_iq_vld;
    logic                  r_iq_last;
    logic                  r_ant_sel;
    logic                  r_err_short;
    logic                  r_err_long;

    logic [ADDR_WIDTH-1:0] w_cnt;
    logic                  w_at_last;
    logic                  w_sop_blk;
    logic                  w_ready;
    logic                  w_accept;
    logic                  w_emit;
    logic                  w_emit_pad;
    logic                  w_last;
    logic                  w_err_short_next;
    logic                  w_err_long_next;

    genvar gi;
    generate
        for (gi = 0; gi < ANT; gi++) begin : g_in_lane
            assign w_in_lane[gi] = iq_lane_t'(i_data[gi*32 +: 32]);
        end
    endgenerate

    re_addr_cnt #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .RE_NUM     (RE_NUM)
    ) u_re_addr_cnt (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_clr     (w_last),
        .i_inc     (w_emit),
        .o_cnt     (w_cnt),
        .o_at_last (w_at_last)
    );

    // A new sop inside RUN is pushed back upstream in the same cycle and held there until the pad completes.
    assign w_sop_blk = (r_state == RUN) && i_vld && i_sop;
    assign w_ready   = r_ready_base && !w_sop_blk;
    assign w_accept  = i_vld && w_ready;
    assign w_last    = w_emit && w_at_last;

    always_comb begin
        w_state_next     = r_state;
        w_emit           = 1'b0;
        w_emit_pad       = 1'b0;
        w_err_short_next = 1'b0;
        w_err_long_next  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept && i_sop) begin
                    w_emit       = 1'b1;
                    w_state_next = i_eop ? PAD : RUN;
                end
            end
            RUN: begin
                if (w_sop_blk) begin
                    w_state_next = PAD;
                end else if (w_accept) begin
                    w_emit = 1'b1;
                    if (w_at_last) begin
                        w_state_next = i_eop ? IDLE : DROP;
                    end else if (i_eop) begin
                        w_state_next = PAD;
                    end
                end
            end
            PAD: begin
                w_emit     = 1'b1;
                w_emit_pad = 1'b1;
                if (w_at_last) begin
                    w_err_short_next = 1'b1;
                    w_state_next     = IDLE;
                end
            end
            DROP: begin
                if (w_accept && i_eop) begin
                    w_err_long_next = 1'b1;
                    w_state_next    = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= IDLE;
            r_ready_base <= 1'b0;
            r_iq_addr    <= '0;
            r_iq_vld     <= 1'b0;
            r_iq_last    <= 1'b0;
            r_ant_sel    <= 1'b0;
            r_err_short  <= 1'b0;
            r_err_long   <= 1'b0;
            for (int li = 0; li < ANT; li++) begin
                r_iq_lane[li] <= '0;
            end
        end else begin
            r_state      <= w_state_next;
            r_ready_base <= (w_state_next != PAD);
            r_iq_vld     <= w_emit;
            r_iq_last    <= w_last;
            r_err_short  <= w_err_short_next;
            r_err_long   <= w_err_long_next;
            // Parity flips once per emitted last, so drops and pads can never desync it from the buffer.
            r_ant_sel    <= r_ant_sel ^ r_iq_last;
            if (w_emit) begin
                r_iq_addr <= w_cnt;
                for (int li = 0; li < ANT; li++) begin
                    r_iq_lane[li] <= w_emit_pad ? '0 : w_in_lane[li];
                end
            end
        end
    end

    generate
        for (gi = 0; gi < OUT_LANES; gi++) begin : g_out_lane
            if (gi < ANT) begin : g_live
                assign o_iq_data[gi*32 +: 32] = r_iq_lane[gi];
            end else begin : g_zero
                assign o_iq_data[gi*32 +: 32] = '0;
            end
        end
    endgenerate

    assign o_ready     = w_ready;
    assign o_iq_addr   = r_iq_addr;
    assign o_iq_vld    = r_iq_vld;
    assign o_iq_last   = r_iq_last;
    assign o_ant_sel   = r_ant_sel;
    assign o_err_short = r_err_short;
    assign o_err_long  = r_err_long;

`ifdef ANT_IQ_FRAMER_STAT_EN
    logic [31:0] r_pkt_cnt;
    logic [15:0] r_short_cnt;
    logic [15:0] r_long_cnt;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_pkt_cnt   <= '0;
            r_short_cnt <= '0;
            r_long_cnt  <= '0;
        end else begin
            r_pkt_cnt   <= r_pkt_cnt + 32'(r_iq_last);
            r_short_cnt <= r_short_cnt + 16'(r_err_short);
            r_long_cnt  <= r_long_cnt + 16'(r_err_long);
        end
    end

    assign o_pkt_cnt   = r_pkt_cnt;
    assign o_short_cnt = r_short_cnt;
    assign o_long_cnt  = r_long_cnt;
`endif

endmodule

// File: tb/tb_ant_iq_framer.sv
// Bench for ant_iq_framer: random IQ packets (well-formed, short, long, sop-interrupted,
// gapped, reset-aborted) checked beat by beat against a packet-level expectation queue.
module tb_ant_iq_framer;

    localparam int ANT    = 4;
    localparam int AW     = 11;
    localparam int RE_NUM = 1584;
    localparam int DW     = ANT * 32;

    typedef struct {
        int           addr;
        logic [DW-1:0] data;
        bit           last;
        bit           err_short;
        bit           is_pad;
        int           acc;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [DW-1:0]   i_data = '0;
    logic            i_vld = 1'b0;
    logic            i_sop = 1'b0;
    logic            i_eop = 1'b0;
    logic            o_ready;
    logic [AW-1:0]   o_iq_addr;
    logic [DW*32-1:0] o_iq_data;
    logic            o_iq_vld;
    logic            o_iq_last;
    logic            o_ant_sel;
    logic            o_err_short;
    logic            o_err_long;
`ifdef ANT_IQ_FRAMER_STAT_EN
    logic [31:0]     pkt_cnt;
    logic [15:0]     short_cnt;
    logic [15:0]     long_cnt;
`endif

    ant_iq_framer #(
        .ANT        (ANT),
        .ADDR_WIDTH (AW),
        .RE_NUM     (RE_NUM)
    ) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_data      (i_data),
        .i_vld       (i_vld),
        .i_sop       (i_sop),
        .i_eop       (i_eop),
        .o_ready     (o_ready),
        .o_iq_addr   (o_iq_addr),
        .o_iq_data   (o_iq_data),
        .o_iq_vld    (o_iq_vld),
        .o_iq_last   (o_iq_last),
        .o_ant_sel   (o_ant_sel),
        .o_err_short (o_err_short),
        .o_err_long  (o_err_long)
`ifdef ANT_IQ_FRAMER_STAT_EN
        ,
        .o_pkt_cnt   (pkt_cnt),
        .o_short_cnt (short_cnt),
        .o_long_cnt  (long_cnt)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   n_cmp = 0;
    int   n_fail = 0;
    exp_t expq[$];
    int   exp_long_cyc = -1;
    bit   exp_sel = 1'b0;
    bit   mon_en = 1'b0;
    int   open_pos = -1;
    int   n_last = 0;
    int   n_short_exp = 0;
    int   n_long_exp = 0;
    int   pkt_no = 0;
    int   prev_cyc = 0;
    bit   prev_pad = 1'b0;
    bit   prev_pad_last = 1'b0;
    exp_t me;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h required %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push_pads(input int from);
        exp_t e;
        for (int a = from; a < RE_NUM; a++) begin
            e.addr      = a;
            e.data      = '0;
            e.last      = (a == RE_NUM - 1);
            e.err_short = (a == RE_NUM - 1);
            e.is_pad    = 1'b1;
            e.acc       = -1;
            expq.push_back(e);
        end
        n_short_exp++;
    endtask

    task automatic drive_beat(input logic [DW-1:0] d, input bit s, input bit e,
                              output bit ok, output int acc, output bit first_rdy);
        ok        = 1'b0;
        acc       = -1;
        first_rdy = 1'b0;
        i_data = d;
        i_vld  = 1'b1;
        i_sop  = s;
        i_eop  = e;
        for (int w = 0; w < 4000 && !ok; w++) begin
            @(negedge clk);
            if (w == 0) first_rdy = o_ready;
            if (o_ready) begin
                ok  = 1'b1;
                acc = cyc;
            end
            @(posedge clk);
            #1;
        end
        i_vld = 1'b0;
        i_sop = 1'b0;
        i_eop = 1'b0;
        if (!ok) begin
            n_cmp++;
            n_fail++;
            $error("FAIL accept_timeout: observed no o_ready within 4000 cycles, required acceptance");
        end
    endtask

    task automatic do_reset_mid_packet();
        #2 rst = 1'b1;
        #1;
        check("rst_async_vld", o_iq_vld, 0);
        check("rst_async_addr", o_iq_addr, 0);
        check("rst_async_data", o_iq_data[DW-1:0], 0);
        check("rst_async_last", o_iq_last, 0);
        check("rst_async_ant_sel", o_ant_sel, 0);
        check("rst_async_ready", o_ready, 0);
        check("rst_async_err", {o_err_short, o_err_long}, 0);
        expq.delete();
        exp_long_cyc  = -1;
        exp_sel       = 1'b0;
        open_pos      = -1;
        prev_pad      = 1'b0;
        prev_pad_last = 1'b0;
        n_last        = 0;
        n_short_exp   = 0;
        n_long_exp    = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic send_pkt(input int len, input int gap_pct, input bit no_eop, input int abort_at);
        bit            ok;
        bit            first_rdy;
        bit            blocked;
        int            acc;
        logic [DW-1:0] d;
        exp_t          e;
        pkt_no++;
        blocked = (open_pos >= 0);
        if (blocked) begin
            push_pads(open_pos);
            open_pos = -1;
        end
        for (int i = 0; i < len; i++) begin
            if (i == abort_at) begin
                $display("pkt %0d: len %0d reset after %0d beats", pkt_no, len, i);
                do_reset_mid_packet();
                return;
            end
            for (int g = 0; g < 8 && $urandom_range(99) < gap_pct; g++) begin
                @(posedge clk);
                #1;
            end
            d = {$urandom, $urandom, $urandom, $urandom};
            drive_beat(d, i == 0, (i == len - 1) && !no_eop, ok, acc, first_rdy);
            if (!ok) return;
            if (i == 0 && blocked) check("sop_hold_ready", first_rdy, 0);
            if (i < RE_NUM) begin
                e.addr      = i;
                e.data      = d;
                e.last      = (i == RE_NUM - 1);
                e.err_short = 1'b0;
                e.is_pad    = 1'b0;
                e.acc       = acc;
                expq.push_back(e);
            end
            if (i == len - 1 && !no_eop) begin
                if (len < RE_NUM) push_pads(len);
                if (len > RE_NUM) begin
                    exp_long_cyc = acc + 1;
                    n_long_exp++;
                end
            end
        end
        if (no_eop) open_pos = len;
        $display("pkt %0d: len %0d gap %0d%% eop %0d sent", pkt_no, len, gap_pct, !no_eop);
    endtask

    task automatic drain();
        for (int w = 0; w < 3000 && expq.size() != 0; w++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        check("drain_queue_empty", expq.size(), 0);
    endtask

    // Output monitor: every cycle checks parity and long pulse, and pops one expected beat per o_iq_vld.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en && !rst) begin
                check("ant_sel", o_ant_sel, exp_sel);
                check("err_long", o_err_long, cyc == exp_long_cyc);
                if (o_iq_vld) begin
                    if (expq.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $error("FAIL unexpected_beat: observed addr %0d, required no beat", o_iq_addr);
                    end else begin
                        me = expq.pop_front();
                        check("addr", o_iq_addr, me.addr);
                        check("data", o_iq_data[DW-1:0], me.data);
                        check("upper_lanes_zero", |o_iq_data[DW*32-1:DW], 0);
                        check("last", o_iq_last, me.last);
                        check("err_short", o_err_short, me.err_short);
                        if (!me.is_pad) check("latency", cyc, me.acc + 1);
                        else if (prev_pad) check("pad_contiguous", cyc, prev_cyc + 1);
                        if (me.addr == 0 && prev_pad_last) check("sop_after_pad", cyc, prev_cyc + 1);
                        prev_cyc      = cyc;
                        prev_pad      = me.is_pad;
                        prev_pad_last = me.is_pad && me.last;
                        if (me.last) begin
                            exp_sel = ~exp_sel;
                            n_last++;
                        end
                    end
                end else begin
                    check("idle_last", o_iq_last, 0);
                    check("idle_err_short", o_err_short, 0);
                end
            end
        end
    end

    initial begin
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_vld", o_iq_vld, 0);
        check("reset_addr", o_iq_addr, 0);
        check("reset_data", o_iq_data[DW-1:0], 0);
        check("reset_last", o_iq_last, 0);
        check("reset_ant_sel", o_ant_sel, 0);
        check("reset_err", {o_err_short, o_err_long}, 0);
        check("reset_ready", o_ready, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("idle_ready", o_ready, 1);
        mon_en = 1'b1;

        send_pkt(RE_NUM, 0, 1'b0, -1);
        send_pkt(RE_NUM, 0, 1'b0, -1);
        send_pkt(1001, 0, 1'b0, -1);
        send_pkt(1600, 0, 1'b0, -1);
        send_pkt(500, 0, 1'b1, -1);
        send_pkt(RE_NUM, 0, 1'b0, -1);
        send_pkt(RE_NUM, 50, 1'b0, -1);
        drain();
`ifdef ANT_IQ_FRAMER_STAT_EN
        check("stat_pkt_cnt", pkt_cnt, n_last);
        check("stat_short_cnt", short_cnt, n_short_exp);
        check("stat_long_cnt", long_cnt, n_long_exp);
`endif

        send_pkt(RE_NUM, 0, 1'b0, 700);
        send_pkt(RE_NUM, 0, 1'b0, -1);
        drain();
`ifdef ANT_IQ_FRAMER_STAT_EN
        check("stat_pkt_cnt_after_rst", pkt_cnt, n_last);
        check("stat_short_cnt_after_rst", short_cnt, n_short_exp);
        check("stat_long_cnt_after_rst", long_cnt, n_long_exp);
`endif

        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ant_iq_framer.md
Name: ant_iq_framer

Overview:
- Upstream neighbour of ant_data_buffer. Turns the per-packet antenna IQ stream from the decompression stage into the addressed write stream that the buffer consumes.
- Each packet carries one antenna group for one symbol: 132 PRB x 12 RE = 1584 beats.
- Generates the RE address and exactly one o_iq_last per packet, and tracks even/odd group parity.
- Repairs malformed packets (zero-pads short packets, truncates long ones) so that even/odd pairing downstream never slips.

Parameters:
- ANT, 4, antenna lanes carried per beat.
- ADDR_WIDTH, 11, RE address width.
- RE_NUM, 1584, beats per packet; must be ≤ 2^ADDR_WIDTH.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  asynchronous active-high reset.
- i_data  in  ANT x 32  per-lane IQ, {I[15:0],Q[15:0]}.
- i_vld  in  1  input beat valid.
- i_sop  in  1  first beat of packet, qualified by i_vld.
- i_eop  in  1  last beat of packet, qualified by i_vld.
- o_ready  out  1  beat accepted when i_vld && o_ready.
- o_iq_addr  out  ADDR_WIDTH  RE index 0..RE_NUM-1.
- o_iq_data  out  (ANT*32) x 32  lanes 0..ANT-1 carry data; remaining lanes are driven 0.
- o_iq_vld  out  1  output beat valid.
- o_iq_last  out  1  beat at address RE_NUM-1.
- o_ant_sel  out  1  parity of the packet being emitted (0 = even group).
- o_err_short  out  1  one-cycle pulse: packet repaired by padding.
- o_err_long  out  1  one-cycle pulse: beats beyond RE_NUM dropped.

Behaviour:
- Reset values: all outputs 0 and state IDLE; additionally the RE counter is 0 and the parity register is 0.
- Reset is asynchronous; asserting it mid-packet abandons the packet with no last and no pulse.
- Latency: every output is registered. An accepted beat appears on o_iq_* exactly 1 cycle later.
- FSM states:
  - IDLE: o_ready=1. Beats without i_sop are dropped silently. An accepted sop beat is emitted at addr 0 and the FSM moves to RUN. An sop beat that also has eop moves to PAD instead, with err_short.
  - RUN: o_ready=1. Each accepted beat is emitted at addr = counter, and the counter increments.
    - Beat at counter RE_NUM-1: emitted with last. If it also carries eop, go to IDLE; otherwise go to DROP.
    - eop at counter < RE_NUM-1: beat emitted normally, then go to PAD.
    - sop while in RUN: that beat is not accepted (o_ready forced to 0 in the same cycle, combinational on i_sop). FSM goes to PAD and the sop beat is held upstream.
  - PAD: o_ready=0. Emits zero data at consecutive addresses each cycle up to RE_NUM-1, with last on the final beat, then goes to IDLE. o_err_short pulses with that last beat.
  - DROP: o_ready=1. Beats are discarded until eop. o_err_long pulses once, on the cycle the eop beat is discarded; then go to IDLE.
- Parity: o_ant_sel toggles on the cycle after each o_iq_last. It is never changed by drops, so it always matches the ant_data_buffer internal selector.
- Counter: saturating compare at RE_NUM-1, not a power-of-2 wrap. It returns to 0 on every exit to IDLE.
- Input i_vld=0 gaps inside RUN are allowed and produce o_iq_vld=0 cycles. PAD is never stalled.

Optional Feature:
- ANT_IQ_FRAMER_STAT_EN defined: adds ports o_pkt_cnt [31:0] (number of o_iq_last), o_short_cnt [15:0] and o_long_cnt [15:0]. These are wrapping counters, cleared by reset and updated one cycle after their events.
- Macro undefined: these ports and their logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package (pusch_pkg): RE_NUM_DEF = 1584, the IQ lane type (32-bit {I,Q}), and the framer state enum {IDLE, RUN, PAD, DROP}.
- Sub-module re_addr_cnt: counter with clear, increment, and at_last flag. It is reusable by ant_data_buffer's read side.

Test Plan:
- Two well-formed 1584-beat packets, continuous valid:
  - addr 0..1583 on each.
  - o_iq_last at beat 1583 of each.
  - o_ant_sel 0 for the first packet and 1 for the second.
  - no error pulses.
- Packet with eop at beat 1000:
  - beats 0..1000 carry data; 1001..1583 are zeros with o_ready=0.
  - one last; err_short pulses with it.
  - next sop accepted the cycle after the last.
- 1600-beat packet:
  - last at 1583; 16 beats dropped.
  - err_long pulses on the eop cycle.
  - parity toggles exactly once.
- sop at beat 500 of a packet:
  - o_ready=0 that cycle; pad 500..1583.
  - the held sop beat emits at addr 0 immediately after the pad's last.
- Random i_vld gaps (50%) over a full packet:
  - output addresses contiguous and data matches input.
  - 1-cycle latency per beat.
- Reset asserted at beat 700:
  - outputs 0 asynchronously; parity 0.
  - a following packet starts at addr 0 with o_ant_sel 0.
- With ANT_IQ_FRAMER_STAT_EN: after the sequence above, o_short_cnt and o_long_cnt match the scenario counts.
